// File: rtl/counter_pkg.sv
// ============================================================================
// Module      : counter_pkg
// Description : Shared direction constants and parameter legality check for
//               the up/down counter family.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package counter_pkg;

   localparam logic DIR_UP = 1'b1;
   localparam logic DIR_DN = 1'b0;

   // True when WIDTH is 2..32 and MODULUS is 2..2**WIDTH.
   function automatic bit params_legal(input int width, input longint modulus);
      return (width >= 2) && (width <= 32) &&
             (modulus >= 2) && (modulus <= (longint'(1) << width));
   endfunction

endpackage

`default_nettype wire

// File: rtl/tff_cell.sv
// ============================================================================
// Module      : tff_cell
// Description : Single toggle flip-flop with synchronous parallel load.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tff_cell (
   input  logic clk,
   input  logic reset,
   input  logic t,
   input  logic load_en,
   input  logic load_d,
   output logic q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= 1'b0;
      end else if (load_en) begin
         q <= load_d;
      end else if (t) begin
         q <= ~q;
      end
   end

endmodule

`default_nettype wire

// File: rtl/sync_updown_counter.sv
// ============================================================================
// Module      : sync_updown_counter
// Description : Modulo-N up/down counter built from a toggle-cell chain, with
//               clear, clamped load, terminal count and wrap pulse.
//               Define COUNTER_SATURATE_EN to saturate instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_updown_counter
   import counter_pkg::*;
#(
   parameter int     WIDTH   = 8,
   parameter longint MODULUS = longint'(1) << WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             up_dn,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   generate
      if (!params_legal(WIDTH, MODULUS)) begin : g_param_check
         $fatal(1, "sync_updown_counter: illegal WIDTH/MODULUS combination");
      end
   endgenerate

   localparam logic [WIDTH-1:0] c_max   = WIDTH'(MODULUS - 1);
   localparam logic [63:0]      c_mod64 = 64'(MODULUS);

   logic             w_up;
   logic             w_term;
   logic             w_count;
   logic             w_load_en;
   logic [WIDTH-1:0] w_load_d;
   logic [WIDTH-1:0] w_clamped;
   logic [WIDTH-1:0] w_ones;
   logic [WIDTH-1:0] w_zeros;
   logic [WIDTH-1:0] w_t;

   assign w_up    = (up_dn == DIR_UP);
   assign w_term  = enable & (w_up ? (q == c_max) : (q == '0));
   assign tc      = w_term;
   assign w_count = enable & ~clear & ~load;

   assign w_clamped = (64'(load_val) >= c_mod64) ? c_max : load_val;

   // Terminal count overrides the chain so non-power-of-two moduli wrap correctly.
   assign w_load_en = clear | load | w_term;

   always_comb begin
      w_load_d = '0;
      if (clear) begin
         w_load_d = '0;
      end else if (load) begin
         w_load_d = w_clamped;
      end else begin
`ifdef COUNTER_SATURATE_EN
         w_load_d = q;
`else
         w_load_d = w_up ? '0 : c_max;
`endif
      end
   end

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
         if (i == 0) begin : g_lsb
            assign w_ones[i]  = 1'b1;
            assign w_zeros[i] = 1'b1;
         end else begin : g_upper
            assign w_ones[i]  = w_ones[i-1]  &  q[i-1];
            assign w_zeros[i] = w_zeros[i-1] & ~q[i-1];
         end

         assign w_t[i] = w_count & (w_up ? w_ones[i] : w_zeros[i]);

         tff_cell u_cell (
            .clk     (clk),
            .reset   (reset),
            .t       (w_t[i]),
            .load_en (w_load_en),
            .load_d  (w_load_d[i]),
            .q       (q[i])
         );
      end
   endgenerate

`ifdef COUNTER_SATURATE_EN
   assign wrap = 1'b0;
`else
   logic r_wrap;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wrap <= 1'b0;
      end else begin
         r_wrap <= w_term & ~clear & ~load;
      end
   end

   assign wrap = r_wrap;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_updown_counter.sv
// ============================================================================
// Module      : tb_sync_updown_counter
// Description : Self-checking bench for sync_updown_counter (4-bit mod-10 and
//               8-bit mod-256 instances) against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sync_updown_counter;

   localparam int M4 = 10;
   localparam int M8 = 256;

   logic       clk;
   logic       reset;
   logic       enable, up_dn, clear, load;
   logic [3:0] load_val;
   logic [3:0] q;
   logic       tc, wrap;

   logic       enable8, up_dn8, clear8, load8;
   logic [7:0] load_val8;
   logic [7:0] q8;
   logic       tc8, wrap8;

   int n_checks = 0;
   int n_fail   = 0;
   int mq       = 0;
   bit mw       = 0;
   int mq8      = 0;
   bit mw8      = 0;

   sync_updown_counter #(.WIDTH(4), .MODULUS(M4)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .up_dn    (up_dn),
      .clear    (clear),
      .load     (load),
      .load_val (load_val),
      .q        (q),
      .tc       (tc),
      .wrap     (wrap)
   );

   sync_updown_counter #(.WIDTH(8), .MODULUS(M8)) u_dut8 (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable8),
      .up_dn    (up_dn8),
      .clear    (clear8),
      .load     (load8),
      .load_val (load_val8),
      .q        (q8),
      .tc       (tc8),
      .wrap     (wrap8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

`ifdef COUNTER_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   function automatic bit at_term(int m, int cur, bit en, bit ud);
      return en && ((ud && cur == m - 1) || (!ud && cur == 0));
   endfunction

   function automatic int next_q(int m, int cur, bit en, bit ud, bit clr, bit ld, int lv);
      if (clr)                  return 0;
      if (ld)                   return (lv >= m) ? m - 1 : lv;
      if (!en)                  return cur;
      if (at_term(m, cur, en, ud)) return SAT ? cur : (ud ? 0 : m - 1);
      return ud ? cur + 1 : cur - 1;
   endfunction

   function automatic bit next_wrap(int m, int cur, bit en, bit ud, bit clr, bit ld);
      if (clr || ld) return 1'b0;
      return !SAT && at_term(m, cur, en, ud);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input bit en, input bit ud, input bit clr, input bit ld, input int lv);
      enable = en; up_dn = ud; clear = clr; load = ld; load_val = 4'(lv);
      #1;
      check("tc", 32'(tc), 32'(at_term(M4, mq, en, ud)));
      @(posedge clk);
      mw = next_wrap(M4, mq, en, ud, clr, ld);
      mq = next_q(M4, mq, en, ud, clr, ld, lv);
      #1;
      check("q", 32'(q), 32'(mq));
      check("wrap", 32'(wrap), 32'(mw));
      enable = 1'b0; clear = 1'b0; load = 1'b0;
   endtask

   task automatic cycle8(input bit en, input bit ud, input bit clr, input bit ld, input int lv);
      enable8 = en; up_dn8 = ud; clear8 = clr; load8 = ld; load_val8 = 8'(lv);
      #1;
      check("tc8", 32'(tc8), 32'(at_term(M8, mq8, en, ud)));
      @(posedge clk);
      mw8 = next_wrap(M8, mq8, en, ud, clr, ld);
      mq8 = next_q(M8, mq8, en, ud, clr, ld, lv);
      #1;
      check("q8", 32'(q8), 32'(mq8));
      check("wrap8", 32'(wrap8), 32'(mw8));
      enable8 = 1'b0; clear8 = 1'b0; load8 = 1'b0;
   endtask

   // Asserts reset between edges and checks the asynchronous clear.
   task automatic mid_cycle_reset(input string tag);
      reset = 1'b1;
      #1;
      mq = 0; mw = 0; mq8 = 0; mw8 = 0;
      check({tag, "_q"}, 32'(q), 32'(0));
      check({tag, "_wrap"}, 32'(wrap), 32'(0));
      check({tag, "_q8"}, 32'(q8), 32'(0));
      @(posedge clk);
      #1 reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b0;
      enable = 1'b0; up_dn = counter_pkg::DIR_UP; clear = 1'b0; load = 1'b0; load_val = '0;
      enable8 = 1'b0; up_dn8 = counter_pkg::DIR_UP; clear8 = 1'b0; load8 = 1'b0; load_val8 = '0;

      // Reset before the first clock edge proves it is asynchronous.
      #2 reset = 1'b1;
      #1;
      check("rst_q", 32'(q), 32'(0));
      check("rst_wrap", 32'(wrap), 32'(0));
      check("rst_q8", 32'(q8), 32'(0));
      @(posedge clk);
      #1 reset = 1'b0;

      // Up-count through a full wrap and beyond.
      for (int i = 0; i < 12; i++) cycle(1, 1, 0, 0, 0);

      // Down-count across zero.
      cycle(0, 0, 1, 0, 0);
      for (int i = 0; i < 3; i++) cycle(1, counter_pkg::DIR_DN, 0, 0, 0);

      // Clamped load, then clear beating load.
      cycle(0, 1, 0, 1, 13);
      cycle(0, 1, 1, 1, 4);
      cycle(1, 1, 0, 1, 15);

      // Direction flip every cycle from 5.
      cycle(0, 1, 0, 1, 5);
      for (int i = 0; i < 4; i++) cycle(1, (i % 2) == 0, 0, 0, 0);

      // Hold with enable low.
      cycle(0, 1, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);

      // Saturation region: up from 8 for four cycles.
      cycle(0, 1, 0, 1, 8);
      for (int i = 0; i < 4; i++) cycle(1, 1, 0, 0, 0);

      // Reset in mid-count at q = 7.
      cycle(0, 1, 0, 1, 7);
      mid_cycle_reset("rst_mid");

      // Reset while a wrap pulse is showing aborts it.
      cycle(0, 1, 0, 1, 9);
      cycle(1, 1, 0, 0, 0);
      mid_cycle_reset("rst_wrap_abort");

      // First enabled edge after reset, both directions.
      cycle(1, 1, 0, 0, 0);
      mid_cycle_reset("rst_again");
      cycle(1, 0, 0, 0, 0);

      // Wide instance: full 255 -> 0 wrap.
      cycle8(0, 1, 0, 1, 250);
      for (int i = 0; i < 8; i++) cycle8(1, 1, 0, 0, 0);
      cycle8(1, 0, 1, 0, 0);
      cycle8(1, 0, 0, 0, 0);

      // Randomized traffic against the model.
      for (int i = 0; i < 300; i++) begin
         cycle($urandom_range(0, 3) != 0,
               $urandom_range(0, 1) == 1,
               $urandom_range(0, 15) == 0,
               $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 15)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sync_updown_counter.md
SYNC_UPDOWN_COUNTER -- requirements
Module: sync_updown_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter width in bits (legal 2..32).
REQ-002 The block SHALL have parameter MODULUS, default 2**WIDTH, count range 0..MODULUS-1 (legal 2..2**WIDTH).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  count-enable qualifier.
REQ-006 The block SHALL have port up_dn  input  1  direction: 1 = up, 0 = down.
REQ-007 The block SHALL have port clear  input  1  synchronous clear to 0.
REQ-008 The block SHALL have port load  input  1  synchronous parallel load.
REQ-009 The block SHALL have port load_val  input  WIDTH  value used by load.
REQ-010 The block SHALL have port q  output  WIDTH  registered count value.
REQ-011 The block SHALL have port tc  output  1  combinational terminal-count indication.
REQ-012 The block SHALL have port wrap  output  1  registered one-cycle wrap pulse.

Function
REQ-013 Per-edge priority SHALL be: clear > load > enable-count > hold.
REQ-014 With clear=1, the next q SHALL be 0 and the next wrap SHALL be 0, regardless of all other inputs.
REQ-015 With load=1 and clear=0, the next q SHALL be load_val; if load_val >= MODULUS, the next q SHALL be MODULUS-1; the next wrap SHALL be 0.
REQ-016 With enable=1, up_dn=1, and q < MODULUS-1, the next q SHALL be q+1.
REQ-017 With enable=1, up_dn=0, and q > 0, the next q SHALL be q-1.
REQ-018 Up-wrap: with enable=1, up_dn=1, and q = MODULUS-1, the next q SHALL be 0 and the next wrap SHALL be 1.
REQ-019 Down-wrap: with enable=1, up_dn=0, and q = 0, the next q SHALL be MODULUS-1 and the next wrap SHALL be 1.
REQ-020 wrap SHALL be 1 for exactly the one cycle following a wrap event, and 0 otherwise.
REQ-021 tc SHALL equal enable AND ((up_dn AND q = MODULUS-1) OR (NOT up_dn AND q = 0)), independent of clear and load.
REQ-022 With enable=0, clear=0 and load=0, q SHALL hold its value.
REQ-023 A direction change SHALL take effect on the same edge, with no bubble cycle.
REQ-024 q SHALL never hold a value >= MODULUS.
REQ-025 The count path SHALL be built as a chain of toggle cells: cell i toggles when its qualified enable is active AND all lower bits are 1 (up) or all lower bits are 0 (down).
REQ-026 Modulus wrap, saturation and load SHALL override the toggle chain when they apply.

Reset
REQ-027 While reset=1, q SHALL be 0 and wrap SHALL be 0, asynchronously, without a clock edge.
REQ-028 Reset asserted mid-count SHALL abort any pending wrap pulse.
REQ-029 After reset deassertion, the first enabled edge SHALL yield q = 1 (up) or q = MODULUS-1 (down).

Configuration
REQ-030 Macro COUNTER_SATURATE_EN SHALL select saturating behaviour.
REQ-031 When COUNTER_SATURATE_EN is defined, the up-wrap and down-wrap conditions of REQ-018/019 SHALL instead hold q at MODULUS-1 and 0 respectively; wrap SHALL be tied to 0; tc behaviour SHALL be unchanged.
REQ-032 When COUNTER_SATURATE_EN is undefined, the wrapping behaviour of REQ-018..020 SHALL apply.

Structure
REQ-033 A shared package counter_pkg SHALL hold the direction constants (DIR_UP = 1, DIR_DN = 0) and the WIDTH/MODULUS legality-check function.
REQ-034 The block SHALL instantiate the sub-module tff_cell (clk, reset, t, load_en, load_d, q) once per bit via a generate loop.
REQ-035 Illegal WIDTH/MODULUS parameter values SHALL be rejected at elaboration.

Verification (WIDTH=4, MODULUS=10 unless stated)
REQ-036 Scenario: reset, then enable=1, up_dn=1 for 12 cycles -> q = 1..9, 0, 1, 2; wrap high only in the cycle after q went 9->0; tc high while q = 9.
REQ-037 Scenario: from q = 0, enable=1, up_dn=0 for 3 cycles -> q = 9, 8, 7; wrap pulses once, in the cycle q = 9.
REQ-038 Scenario: load=1, load_val=13 -> q = 9; then load=1, load_val=4 together with clear=1 -> q = 0.
REQ-039 Scenario: q = 5, enable=1, toggle up_dn every cycle -> q = 6, 5, 6, 5.
REQ-040 Scenario: reset asserted mid-cycle at q = 7 -> q = 0 immediately, without a clock edge; wrap = 0.
REQ-041 Scenario: COUNTER_SATURATE_EN defined, up-count from q = 8 for 4 cycles -> q = 9, 9, 9, 9; wrap stays 0. Also run with WIDTH=8, MODULUS=256: full up-wrap 255->0 with wrap pulse.
